// File: rtl/multicycle_ctrl_pkg.sv
// riscv_ctrl_pkg: shared states, opcodes and control encodings for the multicycle controller
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multicycle controller and its datapath
interface multicycle_ctrl_if #(parameter int RETIRE_CNT_W = 32);
  logic [6:0] op;
  logic zero, mem_ready;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
  logic [RETIRE_CNT_W-1:0] retire_cnt;
  modport master (
    input op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
    output result_src, alu_src_a, alu_src_b, imm_src, alu_op, retire_cnt
  );
  modport slave (
    output op, zero, mem_ready,
    input pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
    input result_src, alu_src_a, alu_src_b, imm_src, alu_op, retire_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_instr_dec.sv
// instr_dec: opcode to immediate-format select
module instr_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);
  assign imm_src = op == OP_SW  ? IMM_S :
                   op == OP_BEQ ? IMM_B :
                   op == OP_JAL ? IMM_J : IMM_I;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM sequencing fetch/decode/execute/writeback of the multicycle RV32I core
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_CNT_W = 32
) (
  input logic clk,
  input logic reset_n,
  multicycle_ctrl_if.master bus
);
  state_t state, next;
  logic ir_load, pc_update, retire, illegal_d, illegal;
  logic [RETIRE_CNT_W-1:0] cnt;

  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = bus.mem_ready ? DECODE : FETCH;
      DECODE:   next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                       bus.op == OP_R   ? EXECR :
                       bus.op == OP_I   ? EXECI :
                       bus.op == OP_BEQ ? BEQ   :
                       bus.op == OP_JAL ? JAL   : FETCH;
      MEMADR:   next = bus.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: next = bus.mem_ready ? FETCH : MEMWRITE;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      JAL:      next = ALUWB;
      default:  next = FETCH;
    endcase
  end

  assign illegal_d = state == DECODE &&
                     !(bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
  assign retire    = state inside {MEMWB, ALUWB, BEQ} || (state == MEMWRITE && bus.mem_ready);
  assign ir_load   = state == FETCH && bus.mem_ready;
  assign pc_update = ir_load || state == JAL;

  // write enables are gated by reset_n so they drop the instant reset asserts
  assign bus.pc_write  = reset_n & ((state == BEQ & bus.zero) | pc_update);
  assign bus.ir_write  = reset_n & ir_load;
  assign bus.mem_write = reset_n & (state == MEMWRITE);
  assign bus.reg_write = reset_n & (state inside {MEMWB, ALUWB});

  assign bus.adr_src    = state inside {MEMREAD, MEMWRITE};
  assign bus.result_src = state == FETCH ? RES_ALURES : state == MEMWB ? RES_DATA : RES_ALUOUT;
  assign bus.alu_src_a  = state inside {DECODE, JAL} ? SRCA_OLDPC :
                          state inside {MEMADR, EXECR, EXECI, BEQ} ? SRCA_RD1 : SRCA_PC;
  assign bus.alu_src_b  = state inside {FETCH, JAL} ? SRCB_4 :
                          state inside {DECODE, MEMADR, EXECI} ? SRCB_IMM : SRCB_RD2;
  assign bus.alu_op     = state inside {EXECR, EXECI} ? ALU_FUNCT :
                          state == BEQ ? ALU_SUB : ALU_ADD;
  assign bus.illegal_instr = illegal;
  assign bus.retire_cnt    = cnt;

  instr_dec u_dec (.op(bus.op), .imm_src(bus.imm_src));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= FETCH;
      cnt     <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= next;
      cnt     <= cnt + RETIRE_CNT_W'(retire);
      illegal <= illegal_d;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for the multicycle controller
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;
  // packed {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, reg_write, alu_op}
  localparam logic [12:0] V_FETCH   = 13'b1_0_0_1_10_00_10_0_00;
  localparam logic [12:0] V_FETCHNR = 13'b0_0_0_0_10_00_10_0_00;
  localparam logic [12:0] V_DECODE  = 13'b0_0_0_0_00_01_01_0_00;
  localparam logic [12:0] V_MEMADR  = 13'b0_0_0_0_00_10_01_0_00;
  localparam logic [12:0] V_MEMREAD = 13'b0_1_0_0_00_00_00_0_00;
  localparam logic [12:0] V_MEMWB   = 13'b0_0_0_0_01_00_00_1_00;
  localparam logic [12:0] V_MEMWR   = 13'b0_1_1_0_00_00_00_0_00;
  localparam logic [12:0] V_EXECR   = 13'b0_0_0_0_00_10_00_0_10;
  localparam logic [12:0] V_EXECI   = 13'b0_0_0_0_00_10_01_0_10;
  localparam logic [12:0] V_ALUWB   = 13'b0_0_0_0_00_00_00_1_00;
  localparam logic [12:0] V_BEQT    = 13'b1_0_0_0_00_10_00_0_01;
  localparam logic [12:0] V_BEQN    = 13'b0_0_0_0_00_10_00_0_01;
  localparam logic [12:0] V_JAL     = 13'b1_0_0_0_00_01_10_0_00;

  logic clk = 1'b0, reset_n = 1'b0;
  int checks = 0, errors = 0, exp_cnt = 0;
  logic [12:0] sig;

  multicycle_ctrl_if #(.RETIRE_CNT_W(8)) bus ();
  multicycle_ctrl #(.RETIRE_CNT_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

  always #5 clk = ~clk;
  assign sig = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.alu_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input string tag, input logic [12:0] v);
    check(tag, 32'(sig), 32'(v));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.op = OP_R; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ir_write", 32'(bus.ir_write), 0);
    check("rst_pc_write", 32'(bus.pc_write), 0);
    check("rst_cnt", 32'(bus.retire_cnt), 0);
    reset_n = 1'b1;
    #1;
    // R-type add
    step("r_fetch", V_FETCH);
    step("r_decode", V_DECODE);
    step("r_execr", V_EXECR);
    step("r_aluwb", V_ALUWB);
    exp_cnt++;
    check("r_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    // lw with a 3-cycle memory stall
    bus.op = OP_LW;
    #1;
    check("lw_imm", 32'(bus.imm_src), 32'(IMM_I));
    step("lw_fetch", V_FETCH);
    step("lw_decode", V_DECODE);
    bus.mem_ready = 1'b0;
    #1;
    step("lw_memadr", V_MEMADR);
    for (int i = 0; i < 3; i++) step("lw_stall", V_MEMREAD);
    bus.mem_ready = 1'b1;
    #1;
    step("lw_memread", V_MEMREAD);
    step("lw_memwb", V_MEMWB);
    exp_cnt++;
    check("lw_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    // sw with fetch stall and one write wait state
    bus.op = OP_SW; bus.mem_ready = 1'b0;
    #1;
    check("sw_imm", 32'(bus.imm_src), 32'(IMM_S));
    step("sw_fetch_wait", V_FETCHNR);
    bus.mem_ready = 1'b1;
    #1;
    step("sw_fetch", V_FETCH);
    step("sw_decode", V_DECODE);
    bus.mem_ready = 1'b0;
    #1;
    step("sw_memadr", V_MEMADR);
    step("sw_memwr_wait", V_MEMWR);
    check("sw_cnt_hold", 32'(bus.retire_cnt), 32'(exp_cnt));
    bus.mem_ready = 1'b1;
    #1;
    step("sw_memwr", V_MEMWR);
    exp_cnt++;
    check("sw_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    // beq taken then not taken
    bus.op = OP_BEQ; bus.zero = 1'b1;
    #1;
    check("beq_imm", 32'(bus.imm_src), 32'(IMM_B));
    step("beqt_fetch", V_FETCH);
    step("beqt_decode", V_DECODE);
    step("beq_taken", V_BEQT);
    exp_cnt++;
    bus.zero = 1'b0;
    #1;
    step("beqn_fetch", V_FETCH);
    step("beqn_decode", V_DECODE);
    step("beq_not_taken", V_BEQN);
    exp_cnt++;
    check("beq_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    // jal
    bus.op = OP_JAL;
    #1;
    check("jal_imm", 32'(bus.imm_src), 32'(IMM_J));
    step("jal_fetch", V_FETCH);
    step("jal_decode", V_DECODE);
    check("jal_imm_jal", 32'(bus.imm_src), 32'(IMM_J));
    step("jal_jal", V_JAL);
    check("jal_cnt_hold", 32'(bus.retire_cnt), 32'(exp_cnt));
    step("jal_aluwb", V_ALUWB);
    exp_cnt++;
    check("jal_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    // illegal opcode
    bus.op = 7'b0000000;
    #1;
    check("ill_pre", 32'(bus.illegal_instr), 0);
    step("ill_fetch", V_FETCH);
    step("ill_decode", V_DECODE);
    check("ill_pulse", 32'(bus.illegal_instr), 1);
    check("ill_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    bus.op = OP_I;
    #1;
    step("ill_back_fetch", V_FETCH);
    check("ill_clear", 32'(bus.illegal_instr), 0);
    step("i_decode", V_DECODE);
    step("i_execi", V_EXECI);
    step("i_aluwb", V_ALUWB);
    exp_cnt++;
    check("i_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    // addi stream up to the 8-bit wrap
    while (exp_cnt != 255) begin
      repeat (4) tick();
      exp_cnt++;
    end
    check("wrap_255", 32'(bus.retire_cnt), 255);
    repeat (4) tick();
    check("wrap_0", 32'(bus.retire_cnt), 0);
    // reset asserted mid-MEMWRITE
    bus.op = OP_SW; bus.mem_ready = 1'b1;
    #1;
    tick();
    bus.mem_ready = 1'b0;
    #1;
    tick();
    tick();
    check("rst_mw_before", 32'(bus.mem_write), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mw_drop", 32'(bus.mem_write), 0);
    check("rst_mw_cnt", 32'(bus.retire_cnt), 0);
    bus.mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_release_fetch", 32'(sig), 32'(V_FETCH));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
